// File: rtl/tetris_pkg.sv
// Shared scan-code and action constants
// for the PS/2 key decoder.
package tetris_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;

  localparam logic [7:0] SC_LEFT  = 8'h1C;
  localparam logic [7:0] SC_RIGHT = 8'h23;
  localparam logic [7:0] SC_ROT   = 8'h1D;
  localparam logic [7:0] SC_DOWN  = 8'h1B;
  localparam logic [7:0] SC_DROP  = 8'h29;

  localparam logic [7:0] SC_X_LEFT  = 8'h6B;
  localparam logic [7:0] SC_X_RIGHT = 8'h74;
  localparam logic [7:0] SC_X_ROT   = 8'h75;
  localparam logic [7:0] SC_X_DOWN  = 8'h72;

  localparam logic [2:0] LEFT  = 3'd0;
  localparam logic [2:0] RIGHT = 3'd1;
  localparam logic [2:0] ROT   = 3'd2;
  localparam logic [2:0] DOWN  = 3'd3;
  localparam logic [2:0] DROP  = 3'd4;

  // Pause key sends E1 followed by 7 bytes.
  localparam logic [2:0] E1_SKIP = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0,
    SKIP_E1
  } kstate_t;

  function automatic logic is_prefix(
    input logic [7:0] b
  );
    return (b == SC_E0) ||
           (b == SC_F0) ||
           (b == SC_E1);
  endfunction

endpackage

// File: rtl/ps2_action_map.sv
// Combinational scan-code to action
// lookup (plain and E0-extended).
module ps2_action_map
  import tetris_pkg::*;
#(
  parameter int ENABLE_ARROWS = 1
) (
  input  logic [7:0] code,
  input  logic       ext,
  output logic       valid,
  output logic [2:0] action
);

  localparam logic ARW = (ENABLE_ARROWS != 0);

  logic xk;
  logic pk;

  assign pk = !ext;
  assign xk = ext && ARW;

  // Decode the code against both key sets
  always_comb begin
    valid  = 1'b0;
    action = LEFT;
    unique case (1'b1)
      (pk && code == SC_LEFT): begin
        valid  = 1'b1;
        action = LEFT;
      end
      (pk && code == SC_RIGHT): begin
        valid  = 1'b1;
        action = RIGHT;
      end
      (pk && code == SC_ROT): begin
        valid  = 1'b1;
        action = ROT;
      end
      (pk && code == SC_DOWN): begin
        valid  = 1'b1;
        action = DOWN;
      end
      (pk && code == SC_DROP): begin
        valid  = 1'b1;
        action = DROP;
      end
      (xk && code == SC_X_LEFT): begin
        valid  = 1'b1;
        action = LEFT;
      end
      (xk && code == SC_X_RIGHT): begin
        valid  = 1'b1;
        action = RIGHT;
      end
      (xk && code == SC_X_ROT): begin
        valid  = 1'b1;
        action = ROT;
      end
      (xk && code == SC_X_DOWN): begin
        valid  = 1'b1;
        action = DOWN;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 byte stream to game-action
// press pulses and held levels.
module ps2_key_decoder
  import tetris_pkg::*;
#(
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000,
  parameter int          ENABLE_ARROWS  = 1
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       rot_pulse,
  output logic       drop_pulse,
  output logic       down_held,
  output logic [4:0] held,
  output logic       seq_error
);

  kstate_t     state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [15:0] cnt_q;
  logic [4:0]  held_q, held_d;

  logic       mk;
  logic       brk;
  logic       ext;
  logic       err_d;
  logic       press;
  logic       timeout;
  logic       map_valid;
  logic [2:0] map_action;

  assign timeout = (state_q != IDLE) &&
                   (cnt_q >= PREFIX_TIMEOUT);

  ps2_action_map #(
    .ENABLE_ARROWS(ENABLE_ARROWS)
  ) u_map (
    .code  (received_data),
    .ext   (ext),
    .valid (map_valid),
    .action(map_action)
  );

  // State, counters and registered outputs
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      skip_q      <= '0;
      cnt_q       <= '0;
      held_q      <= '0;
      left_pulse  <= 1'b0;
      right_pulse <= 1'b0;
      rot_pulse   <= 1'b0;
      drop_pulse  <= 1'b0;
      down_held   <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      held_q  <= held_d;
      if (received_data_en || state_q == IDLE)
        cnt_q <= '0;
      else if (cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
      left_pulse  <= press && map_action == LEFT;
      right_pulse <= press && map_action == RIGHT;
      rot_pulse   <= press && map_action == ROT;
      drop_pulse  <= press && map_action == DROP;
      down_held   <= held_d[DOWN];
      seq_error   <= err_d;
    end
  end

  // Byte sequencing; a strobe beats a timeout
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    mk      = 1'b0;
    brk     = 1'b0;
    ext     = 1'b0;
    err_d   = 1'b0;
    if (received_data_en) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            (received_data == SC_E0):
              state_d = GOT_E0;
            (received_data == SC_F0):
              state_d = GOT_F0;
            (received_data == SC_E1): begin
              state_d = SKIP_E1;
              skip_d  = E1_SKIP;
            end
            default: mk = 1'b1;
          endcase
        end
        GOT_E0: begin
          ext = 1'b1;
          if (received_data == SC_F0)
            state_d = GOT_E0F0;
          else begin
            mk      = 1'b1;
            state_d = IDLE;
          end
        end
        GOT_F0, GOT_E0F0: begin
          ext     = (state_q == GOT_E0F0);
          state_d = IDLE;
          if (is_prefix(received_data))
            err_d = 1'b1;
          else
            brk = 1'b1;
        end
        SKIP_E1: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      skip_d  = '0;
      err_d   = 1'b1;
    end
  end

  // Held-state update and new-press detect
  always_comb begin
    held_d = held_q;
    press  = 1'b0;
    if (mk && map_valid) begin
      press = !held_q[map_action];
      held_d[map_action] = 1'b1;
    end else if (brk && map_valid) begin
      held_d[map_action] = 1'b0;
    end
  end

  assign held = held_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter PREFIX_TIMEOUT, default 16'd50000, the number of clock cycles a partial sequence waits for its next byte before being abandoned.
REQ-002 SHALL have parameter ENABLE_ARROWS, default 1, which enables the E0-extended arrow-key mappings.
REQ-003 Port: CLOCK_50  in  1  system clock; one clock, all logic on its rising edge.
REQ-004 Port: resetn  in  1  reset, asynchronous, active-low.
REQ-005 Port: received_data  in  8  PS/2 byte from PS2_Controller.
REQ-006 Port: received_data_en  in  1  one-cycle strobe; received_data is valid only while this is high.
REQ-007 Port: left_pulse, right_pulse, rot_pulse, drop_pulse  out  1 each  one-cycle press events.
REQ-008 Port: down_held  out  1  level signal, high while soft-drop key(s) are held.
REQ-009 Port: held  out  5  per-action held state; bit order {drop, down, rot, right, left} = bits [4:0].
REQ-010 Port: seq_error  out  1  one-cycle strobe on an abandoned or malformed sequence.

Function
REQ-011 Byte FSM states SHALL be: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_E1.
REQ-012 In IDLE, byte E0 -> GOT_E0; F0 -> GOT_F0; E1 -> SKIP_E1 with skip count 7; any other byte is a plain make code, FSM stays in IDLE.
REQ-013 In GOT_E0, byte F0 -> GOT_E0F0; any other byte is an extended make code -> IDLE.
REQ-014 In GOT_F0 and GOT_E0F0, the byte is the plain or extended break code respectively -> IDLE.
REQ-015 In SKIP_E1, each byte decrements the skip count; on reaching 0 -> IDLE; skipped bytes SHALL produce no events.
REQ-016 Plain mapping SHALL be: 1C left, 23 right, 1D rot, 1B down, 29 drop.
REQ-017 Extended mapping, active only when ENABLE_ARROWS=1, SHALL be: 6B left, 74 right, 75 rot, 72 down.
REQ-018 Unmapped codes SHALL be ignored silently; with ENABLE_ARROWS=0, extended codes are unmapped.
REQ-019 A make of mapped action a with held[a]=0 SHALL set held[a] and pulse the corresponding pulse output.
REQ-020 A make with held[a]=1 is typematic repeat and SHALL produce no pulse.
REQ-021 A break of action a SHALL clear held[a] and SHALL produce no pulse.
REQ-022 held[a] SHALL be a single bit shared by the plain and extended keys for the same action: a break from either key clears it.
REQ-023 Pulse latency SHALL be exactly 1 cycle: the pulse is high in the cycle after the strobe of the final byte, for 1 cycle.
REQ-024 down_held SHALL equal held[3], driven registered.
REQ-025 The timeout counter SHALL reload to 0 on every strobe and count while the FSM is not IDLE, saturating at 16 bits.
REQ-026 When the counter reaches PREFIX_TIMEOUT with no strobe -> IDLE, seq_error pulses, and held is unchanged.
REQ-027 When a strobe and the timeout coincide in the same cycle, the byte SHALL win: it is processed from the current state and no seq_error is raised.
REQ-028 An E0, F0 or E1 byte received in GOT_F0 or GOT_E0F0 is malformed: seq_error pulses, the FSM goes to IDLE, and the byte is then discarded.
REQ-029 At most one pulse output SHALL be high in any cycle, since at most one byte is processed per cycle.

Reset
REQ-030 On resetn=0, asynchronously: FSM -> IDLE; skip count, timeout counter and held -> 0; all pulse outputs, down_held and seq_error -> 0.
REQ-031 Reset during a partial sequence SHALL discard that sequence; the first byte after reset is decoded from IDLE.

Structure
REQ-032 A shared package tetris_pkg SHALL hold the scan-code constants (E0, F0, E1, and the mapped codes) and the action index constants LEFT=0, RIGHT=1, ROT=2, DOWN=3, DROP=4.
REQ-033 The code-to-action lookup SHALL be one combinational sub-module ps2_action_map, with inputs code[7:0] and ext and outputs valid and action[2:0].
REQ-034 All state and outputs SHALL be registered; there are no combinational paths from input to output.

Verification
REQ-035 Strobe 1C -> left_pulse=1 for one cycle, 1 cycle later; held=00001; then F0,1C -> held=00000 with no pulse.
REQ-036 Send 1C,1C,1C (typematic) -> exactly one left_pulse; then F0,1C then 1C -> a second left_pulse.
REQ-037 Send E0,75 -> rot_pulse; with ENABLE_ARROWS=0, E0,75 -> no pulse and held=0.
REQ-038 Send E1 plus 7 bytes that include 1C -> no pulses; the next byte 23 -> right_pulse.
REQ-039 Send E0, then no byte for PREFIX_TIMEOUT cycles -> seq_error pulse and FSM in IDLE; then 1B -> down_held=1.
REQ-040 Assert resetn=0 after F0, then release and send 29 -> drop_pulse; held[4]=1.
